data_io_stream: RTL and testbench

//  Parametrised successor of the pin-level input shim. Host drives a narrow packed pin bus and

---
 rtl/data_io_pkg.sv | 24 ++
 rtl/io_fifo.sv | 53 +++++
 rtl/data_io_stream.sv | 111 +++++++++++
 tb/tb_data_io_stream.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_io_pkg.sv
// Shared defaults, derived widths and pin-field offsets for the pin-level stream input block.
package data_io_pkg;

  localparam int SEG_W    = 19;
  localparam int NSEG     = 2;
  localparam int OP_W     = 2;
  localparam int DEPTH    = 4;
  localparam int RES_W    = 6;
  localparam int WORD_W   = SEG_W * NSEG;
  localparam int PIN_W    = OP_W + 2 + SEG_W;
  localparam int CNT_W    = $clog2(DEPTH) + 1;
  localparam int TOG_BIT  = SEG_W;
  localparam int LAST_BIT = SEG_W + 1;
  localparam int OP_LSB   = SEG_W + 2;

  // Edge detection stays disabled until the synchroniser and the baseline hold real pin samples
  typedef enum logic [1:0] {
    ARM_FILL0,
    ARM_FILL1,
    ARM_FILL2,
    ARM_LIVE
  } arm_state_t;

endpackage

// File: rtl/io_fifo.sv
// First-word-fall-through FIFO; the head entry reads as zero while the FIFO is empty.
module io_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot that a push into a full FIFO overwrites
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/data_io_stream.sv
// Pin-level toggle-strobed segment input: synchronise, assemble NSEG segments MSB-first,
// queue {opcode, word} for the core, and return core result plus buffer flags on pins.
module data_io_stream #(
  parameter int SEG_W = data_io_pkg::SEG_W,
  parameter int NSEG  = data_io_pkg::NSEG,
  parameter int OP_W  = data_io_pkg::OP_W,
  parameter int DEPTH = data_io_pkg::DEPTH,
  parameter int RES_W = data_io_pkg::RES_W
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [OP_W+SEG_W+1:0]   pin_in,
  output logic                    core_valid,
  input  logic                    core_ready,
  output logic [OP_W-1:0]         core_op,
  output logic [SEG_W*NSEG-1:0]   core_data,
  input  logic [RES_W-1:0]        core_res,
  output logic [RES_W+1:0]        pin_out
);

  import data_io_pkg::*;

  localparam int WORD_W = SEG_W * NSEG;
  localparam int SCNT_W = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int T_BIT  = SEG_W;
  localparam int L_BIT  = SEG_W + 1;
  localparam int O_LSB  = SEG_W + 2;

  logic                     tog_s1;
  logic                     tog_s;
  logic                     tog_q;
  arm_state_t               arm;
  logic                     tog_event;
  logic                     complete;
  logic [SCNT_W-1:0]        seg_cnt;
  logic [WORD_W-1:0]        acc;
  logic [WORD_W+SEG_W-1:0]  acc_ext;
  logic [WORD_W-1:0]        acc_next;
  logic [SEG_W-1:0]         seg;
  logic                     last;
  logic [OP_W-1:0]          op;
  logic                     pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     ovf_sticky;
  logic [RES_W-1:0]         res_q;

  assign seg       = pin_in[SEG_W-1:0];
  assign last      = pin_in[L_BIT];
  assign op        = pin_in[O_LSB +: OP_W];
  assign tog_event = (arm == ARM_LIVE) && (tog_s != tog_q);
  assign complete  = tog_event && (last || (seg_cnt == SCNT_W'(NSEG - 1)));
  assign acc_ext   = {acc, seg};
  assign acc_next  = acc_ext[WORD_W-1:0];
  assign pop       = core_valid && core_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tog_s1 <= 1'b0;
      tog_s  <= 1'b0;
      tog_q  <= 1'b0;
      arm    <= ARM_FILL0;
    end else begin
      tog_s1 <= pin_in[T_BIT];
      tog_s  <= tog_s1;
      tog_q  <= tog_s;
      case (arm)
        ARM_FILL0: arm <= ARM_FILL1;
        ARM_FILL1: arm <= ARM_FILL2;
        default:   arm <= ARM_LIVE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seg_cnt    <= '0;
      acc        <= '0;
      ovf_sticky <= 1'b0;
      res_q      <= '0;
    end else begin
      res_q <= core_res;
      if (complete) begin
        seg_cnt <= '0;
        acc     <= '0;
      end else if (tog_event) begin
        seg_cnt <= seg_cnt + 1'b1;
        acc     <= acc_next;
      end
      if (complete && fifo_full && !pop) ovf_sticky <= 1'b1;
    end
  end

  io_fifo #(
    .W     (OP_W + WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (complete),
    .pop   (pop),
    .wdata ({op, acc_next}),
    .rdata ({core_op, core_data}),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign core_valid = !fifo_empty;
  assign pin_out    = {ovf_sticky, fifo_full, res_q};

endmodule

// File: tb/tb_data_io_stream.sv
// Scoreboard bench: host-level word model feeds an expected queue, a monitor pops on handshakes.
module tb_data_io_stream;

  import data_io_pkg::*;

  typedef logic [OP_W+WORD_W-1:0] ent_t;

  logic               clk = 1'b0;
  logic               rstn;
  logic [PIN_W-1:0]   pin_in;
  logic               core_valid;
  logic               core_ready;
  logic [OP_W-1:0]    core_op;
  logic [WORD_W-1:0]  core_data;
  logic [RES_W-1:0]   core_res;
  logic [RES_W+1:0]   pin_out;

  int             tests = 0;
  int             fails = 0;
  ent_t           exp_q[$];
  logic [SEG_W-1:0] part_q[$];
  bit             exp_ovf;
  bit             ready_level;
  logic           tog;
  ent_t           mon_e;

  data_io_stream dut (
    .clk        (clk),
    .rstn       (rstn),
    .pin_in     (pin_in),
    .core_valid (core_valid),
    .core_ready (core_ready),
    .core_op    (core_op),
    .core_data  (core_data),
    .core_res   (core_res),
    .pin_out    (pin_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model one host segment write: words are the segments concatenated MSB-first
  task automatic applyStimulus(input logic [OP_W-1:0] op, input bit last, input logic [SEG_W-1:0] seg,
                               input bit rdy_evt, input bit chk_lat);
    logic [WORD_W-1:0] w;
    core_ready = ready_level;
    part_q.push_back(seg);
    if (last || part_q.size() == NSEG) begin
      w = '0;
      foreach (part_q[i]) w = (w << SEG_W) | WORD_W'(part_q[i]);
      part_q.delete();
      if (exp_q.size() >= DEPTH && !rdy_evt) exp_ovf = 1'b1;
      else exp_q.push_back({op, w});
    end
    tog    = ~tog;
    pin_in = {op, last, tog, seg};
    repeat (2) @(posedge clk);
    #1;
    if (chk_lat) checkOutput("latency_early", 64'(core_valid), 64'd0);
    core_ready = rdy_evt;
    @(posedge clk);
    #1;
    core_ready = ready_level;
    @(posedge clk);
    #1;
    if (chk_lat) checkOutput("latency_valid", 64'(core_valid), 64'd1);
  endtask

  task automatic clearModel();
    exp_q.delete();
    part_q.delete();
    exp_ovf = 1'b0;
  endtask

  task automatic doReset();
    core_ready  = 1'b0;
    ready_level = 1'b0;
    rstn        = 1'b0;
    clearModel();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    ready_level = 1'b1;
    core_ready  = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput("drain_left", 64'(exp_q.size()), 64'd0);
    checkOutput("drain_valid", 64'(core_valid), 64'd0);
  endtask

  // Monitor: every accepted head must match the oldest expected entry
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (core_valid && core_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_word", 64'({core_op, core_data}), 64'hDEAD);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("word", 64'({core_op, core_data}), 64'(mon_e));
        end
      end else if (!core_valid) begin
        checkOutput("empty_zero", 64'({core_op, core_data}), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tog         = 1'b1;
    pin_in      = {OP_W'(0), 1'b0, tog, SEG_W'(0)};
    core_ready  = 1'b0;
    core_res    = '0;
    rstn        = 1'b0;
    ready_level = 1'b0;
    clearModel();
    #12;
    checkOutput("reset_valid", 64'(core_valid), 64'd0);
    checkOutput("reset_flags", 64'(pin_out[RES_W+1:RES_W]), 64'd0);
    checkOutput("reset_data", 64'({core_op, core_data}), 64'd0);

    // Toggle held high from reset release must not produce an event
    doReset();
    for (int i = 0; i < 10; i++) begin
      checkOutput("idle_tog_high", 64'(core_valid), 64'd0);
      @(posedge clk);
      #1;
    end

    // Two-segment word with latency check
    applyStimulus(2'd0, 1'b0, 19'h7FFFF, 1'b0, 1'b0);
    applyStimulus(2'd2, 1'b0, 19'h00001, 1'b0, 1'b1);
    checkOutput("t2_data", 64'(core_data), 64'h3F_FFF8_0001);
    checkOutput("t2_op", 64'(core_op), 64'd2);
    drain();

    // Early last, then a normal word
    ready_level = 1'b1;
    applyStimulus(2'd1, 1'b1, 19'h5, 1'b1, 1'b0);
    applyStimulus(2'd3, 1'b0, SEG_W'($urandom), 1'b1, 1'b0);
    applyStimulus(2'd0, 1'b0, SEG_W'($urandom), 1'b1, 1'b0);
    drain();

    // Core result returns with one cycle of latency
    for (int i = 0; i < 4; i++) begin
      logic [RES_W-1:0] r;
      r = RES_W'($urandom);
      core_res = r;
      @(posedge clk);
      #1;
      checkOutput("res_pipe", 64'(pin_out[RES_W-1:0]), 64'(r));
    end

    // Overflow: DEPTH+1 words with the core stalled
    ready_level = 1'b0;
    for (int w = 0; w < DEPTH + 1; w++) begin
      applyStimulus(OP_W'($urandom), 1'b0, SEG_W'($urandom), 1'b0, 1'b0);
      applyStimulus(OP_W'($urandom), 1'b0, SEG_W'($urandom), 1'b0, 1'b0);
      if (w == DEPTH - 1) begin
        checkOutput("t4_full", 64'(pin_out[RES_W]), 64'd1);
        checkOutput("t4_no_ovf", 64'(pin_out[RES_W+1]), 64'd0);
      end
    end
    checkOutput("t4_ovf", 64'(pin_out[RES_W+1]), 64'(exp_ovf));
    drain();
    checkOutput("t4_full_clear", 64'(pin_out[RES_W]), 64'd0);
    checkOutput("t4_ovf_sticky", 64'(pin_out[RES_W+1]), 64'd1);

    // Completion coinciding with a pop while full
    doReset();
    for (int w = 0; w < DEPTH; w++) begin
      applyStimulus(OP_W'($urandom), 1'b0, SEG_W'($urandom), 1'b0, 1'b0);
      applyStimulus(OP_W'($urandom), 1'b0, SEG_W'($urandom), 1'b0, 1'b0);
    end
    checkOutput("t5_full_before", 64'(pin_out[RES_W]), 64'd1);
    applyStimulus(OP_W'($urandom), 1'b0, SEG_W'($urandom), 1'b0, 1'b0);
    applyStimulus(OP_W'($urandom), 1'b0, SEG_W'($urandom), 1'b1, 1'b0);
    checkOutput("t5_full_after", 64'(pin_out[RES_W]), 64'd1);
    checkOutput("t5_ovf", 64'(pin_out[RES_W+1]), 64'd0);
    drain();

    // Asynchronous reset mid-word with two entries queued
    ready_level = 1'b0;
    for (int s = 0; s < 5; s++)
      applyStimulus(OP_W'($urandom), 1'b0, SEG_W'($urandom), 1'b0, 1'b0);
    checkOutput("t6_queued", 64'(core_valid), 64'd1);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    checkOutput("t6_valid_async", 64'(core_valid), 64'd0);
    checkOutput("t6_flags", 64'(pin_out[RES_W+1:RES_W]), 64'd0);
    clearModel();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    ready_level = 1'b1;
    applyStimulus(OP_W'($urandom), 1'b0, SEG_W'($urandom), 1'b1, 1'b0);
    applyStimulus(OP_W'($urandom), 1'b0, SEG_W'($urandom), 1'b1, 1'b0);
    drain();

    // Randomised segments, opcodes, early lasts and core stalls
    for (int s = 0; s < 40; s++) begin
      ready_level = 1'($urandom_range(1));
      applyStimulus(OP_W'($urandom), ($urandom_range(3) == 0), SEG_W'($urandom), ready_level, 1'b0);
      checkOutput("rand_full", 64'(pin_out[RES_W]), 64'(exp_q.size() == DEPTH));
    end
    checkOutput("rand_ovf", 64'(pin_out[RES_W+1]), 64'(exp_ovf));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
